// File: rtl/stopwatch_tx_formatter.sv
// Formats a snapshot of the stopwatch digits as "M:SS.T[\r\n]".
// The bytes are handed to uart_tx one at a time using its tx_start / tx_done_tick handshake.
module stopwatch_tx_formatter #(
  parameter bit         APPEND_CRLF = 1'b1,
  parameter logic [7:0] SEP_MIN     = 8'h3A,
  parameter logic [7:0] SEP_FRAC    = 8'h2E
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       send,
  input  logic [3:0] d3,
  input  logic [3:0] d2,
  input  logic [3:0] d1,
  input  logic [3:0] d0,
  input  logic       tx_done_tick,
  output logic       tx_start,
  output logic [7:0] tx_data,
  output logic       busy,
  output logic       done_tick
);

  typedef enum logic [1:0] {IDLE, LOAD, WAIT, FIN} state_t;

  localparam logic [2:0] LAST_IDX = APPEND_CRLF ? 3'd7 : 3'd5;

  state_t      state, state_next;
  logic [2:0]  idx, idx_next;
  logic [15:0] snap, snap_next;
  logic        tx_start_next, busy_next, done_next;
  logic [7:0]  tx_data_next;

  function automatic logic [7:0] to_ascii(input logic [3:0] d);
    logic [7:0] a;
    if (d <= 4'd9) a = 8'h30 + {4'h0, d};
    else           a = 8'h3F;
    return a;
  endfunction

  function automatic logic [7:0] msg_byte(input logic [2:0] i, input logic [15:0] digits);
    logic [7:0] b;
    case (i)
      3'd0:    b = to_ascii(digits[15:12]);
      3'd1:    b = SEP_MIN;
      3'd2:    b = to_ascii(digits[11:8]);
      3'd3:    b = to_ascii(digits[7:4]);
      3'd4:    b = SEP_FRAC;
      3'd5:    b = to_ascii(digits[3:0]);
      3'd6:    b = 8'h0D;
      3'd7:    b = 8'h0A;
      default: b = 8'h00;
    endcase
    return b;
  endfunction

  // State and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      idx       <= 3'd0;
      snap      <= 16'h0000;
      tx_start  <= 1'b0;
      tx_data   <= 8'h00;
      busy      <= 1'b0;
      done_tick <= 1'b0;
    end else begin
      state     <= state_next;
      idx       <= idx_next;
      snap      <= snap_next;
      tx_start  <= tx_start_next;
      tx_data   <= tx_data_next;
      busy      <= busy_next;
      done_tick <= done_next;
    end
  end

  // Next-state logic; output values are computed one cycle ahead so that every output is registered
  always_comb begin
    state_next    = state;
    idx_next      = idx;
    snap_next     = snap;
    tx_start_next = 1'b0;
    tx_data_next  = tx_data;
    busy_next     = busy;
    done_next     = 1'b0;
    case (state)
      IDLE: begin
        if (send) begin
          snap_next     = {d3, d2, d1, d0};
          idx_next      = 3'd0;
          state_next    = LOAD;
          busy_next     = 1'b1;
          tx_start_next = 1'b1;
          tx_data_next  = msg_byte(3'd0, {d3, d2, d1, d0});
        end else begin
          state_next = IDLE;
        end
      end
      LOAD: begin
        state_next = WAIT;
      end
      WAIT: begin
        if (tx_done_tick) begin
          if (idx == LAST_IDX) begin
            state_next = FIN;
            done_next  = 1'b1;
          end else begin
            idx_next      = idx + 3'd1;
            state_next    = LOAD;
            tx_start_next = 1'b1;
            tx_data_next  = msg_byte(idx + 3'd1, snap);
          end
        end else begin
          state_next = WAIT;
        end
      end
      FIN: begin
        state_next = IDLE;
        busy_next  = 1'b0;
      end
      default: begin
        state_next = IDLE;
        busy_next  = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_stopwatch_tx_formatter.sv
// Directed bench: two formatters (with and without CR/LF), each paired with a uart_tx model
// that returns tx_done_tick 20 cycles after tx_start.
module tb_stopwatch_tx_formatter;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       send_a = 1'b0, send_b = 1'b0;
  logic [3:0] d3 = 4'd0, d2 = 4'd0, d1 = 4'd0, d0 = 4'd0;
  logic       stray_a = 1'b0;
  logic       mdone_a, mdone_b, tx_done_a, tx_done_b;
  logic       tx_start_a, tx_start_b, busy_a, busy_b, done_tick_a, done_tick_b;
  logic [7:0] tx_data_a, tx_data_b;
  logic [4:0] cnt_a, cnt_b;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  assign tx_done_a = mdone_a | stray_a;
  assign tx_done_b = mdone_b;

  stopwatch_tx_formatter #(.APPEND_CRLF(1'b1)) dut_a (
    .clk(clk), .reset(reset), .send(send_a), .d3(d3), .d2(d2), .d1(d1), .d0(d0),
    .tx_done_tick(tx_done_a), .tx_start(tx_start_a), .tx_data(tx_data_a),
    .busy(busy_a), .done_tick(done_tick_a));

  stopwatch_tx_formatter #(.APPEND_CRLF(1'b0)) dut_b (
    .clk(clk), .reset(reset), .send(send_b), .d3(d3), .d2(d2), .d1(d1), .d0(d0),
    .tx_done_tick(tx_done_b), .tx_start(tx_start_b), .tx_data(tx_data_b),
    .busy(busy_b), .done_tick(done_tick_b));

  // uart_tx models: done pulse 20 cycles after start
  always @(posedge clk) begin
    if (reset) begin
      cnt_a <= 5'd0; mdone_a <= 1'b0; cnt_b <= 5'd0; mdone_b <= 1'b0;
    end else begin
      mdone_a <= 1'b0;
      mdone_b <= 1'b0;
      if (tx_start_a) cnt_a <= 5'd20;
      else if (cnt_a != 5'd0) begin
        cnt_a <= cnt_a - 5'd1;
        if (cnt_a == 5'd1) mdone_a <= 1'b1;
      end
      if (tx_start_b) cnt_b <= 5'd20;
      else if (cnt_b != 5'd0) begin
        cnt_b <= cnt_b - 5'd1;
        if (cnt_b == 5'd1) mdone_b <= 1'b1;
      end
    end
  end

  // Monitors record transmitted bytes and handshake events
  logic [7:0] bytes_a[$];
  logic [7:0] bytes_b[$];
  int cyc = 0, start_cnt_a = 0, start_cnt_b = 0, done_cnt_a = 0, done_cnt_b = 0;
  int consec_err = 0, done_cyc_b = 0, txdone_cyc_b = 0;
  logic prev_a = 1'b0, prev_b = 1'b0;

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (tx_start_a) begin
      bytes_a.push_back(tx_data_a);
      start_cnt_a = start_cnt_a + 1;
      if (prev_a) consec_err = consec_err + 1;
    end
    if (tx_start_b) begin
      bytes_b.push_back(tx_data_b);
      start_cnt_b = start_cnt_b + 1;
      if (prev_b) consec_err = consec_err + 1;
    end
    prev_a = tx_start_a;
    prev_b = tx_start_b;
    if (done_tick_a) done_cnt_a = done_cnt_a + 1;
    if (done_tick_b) begin
      done_cnt_b = done_cnt_b + 1;
      done_cyc_b = cyc;
    end
    if (tx_done_b) txdone_cyc_b = cyc;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors = vectors + 1;
    if (obs !== exp) begin
      miscompares = miscompares + 1;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic set_digits(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c, input logic [3:0] d);
    d3 = a; d2 = b; d1 = c; d0 = d;
  endtask

  task automatic wait_done_a(input int base);
    for (int i = 0; i < 2000; i++) begin
      if (done_cnt_a != base) break;
      tick(1);
    end
    check("done_a_seen", done_cnt_a - base, 1);
  endtask

  task automatic check_msg_a(input string tag, input int base, input logic [63:0] exp);
    logic [63:0] e;
    e = exp;
    check({tag, "_len"}, bytes_a.size() - base, 8);
    for (int i = 0; i < 8; i++)
      if (base + i < bytes_a.size())
        check($sformatf("%s_byte%0d", tag, i), bytes_a[base + i], e[63 - 8*i -: 8]);
  endtask

  int bb, bs, bd;

  initial begin
    // Reset state
    tick(3);
    check("rst_tx_start", tx_start_a, 0);
    check("rst_tx_data", tx_data_a, 8'h00);
    check("rst_busy", busy_a, 0);
    check("rst_done", done_tick_a, 0);
    reset = 1'b0;
    tick(2);

    // Test 1: normal message, first-start latency, done tick in LOAD ignored
    set_digits(4'd1, 4'd2, 4'd3, 4'd4);
    bb = bytes_a.size(); bs = start_cnt_a; bd = done_cnt_a;
    check("t1_idle_start", tx_start_a, 0);
    send_a = 1'b1;
    tick(1);
    send_a = 1'b0;
    check("t1_first_start", tx_start_a, 1);
    check("t1_busy", busy_a, 1);
    stray_a = 1'b1;
    tick(1);
    stray_a = 1'b0;
    wait_done_a(bd);
    tick(3);
    check_msg_a("t1", bb, 64'h31_3A_32_33_2E_34_0D_0A);
    check("t1_starts", start_cnt_a - bs, 8);
    check("t1_dones", done_cnt_a - bd, 1);
    check("t1_busy_after", busy_a, 0);

    // Test 2: no CR/LF, done tick one cycle after last tx_done_tick
    set_digits(4'd9, 4'd5, 4'd9, 4'd9);
    send_b = 1'b1;
    tick(1);
    send_b = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if (done_cnt_b != 0) break;
      tick(1);
    end
    tick(3);
    check("t2_starts", start_cnt_b, 6);
    check("t2_dones", done_cnt_b, 1);
    check("t2_latency", done_cyc_b - txdone_cyc_b, 1);
    check("t2_len", bytes_b.size(), 6);
    if (bytes_b.size() == 6) begin
      check("t2_b0", bytes_b[0], 8'h39); check("t2_b1", bytes_b[1], 8'h3A);
      check("t2_b2", bytes_b[2], 8'h35); check("t2_b3", bytes_b[3], 8'h39);
      check("t2_b4", bytes_b[4], 8'h2E); check("t2_b5", bytes_b[5], 8'h39);
    end
    check("t2_busy_after", busy_b, 0);

    // Test 3: snapshot holds, send while busy and during FIN ignored
    set_digits(4'd0, 4'd0, 4'd0, 4'd0);
    bb = bytes_a.size(); bs = start_cnt_a; bd = done_cnt_a;
    send_a = 1'b1;
    tick(1);
    send_a = 1'b0;
    tick(60);
    set_digits(4'd7, 4'd7, 4'd7, 4'd7);
    send_a = 1'b1;
    tick(1);
    send_a = 1'b0;
    wait_done_a(bd);
    send_a = 1'b1;
    tick(1);
    send_a = 1'b0;
    tick(30);
    check_msg_a("t3", bb, 64'h30_3A_30_30_2E_30_0D_0A);
    check("t3_starts", start_cnt_a - bs, 8);
    check("t3_dones", done_cnt_a - bd, 1);
    check("t3_busy_after", busy_a, 0);

    // Test 4: non-BCD digits become '?'
    set_digits(4'hA, 4'd1, 4'd2, 4'hF);
    bb = bytes_a.size(); bd = done_cnt_a;
    send_a = 1'b1;
    tick(1);
    send_a = 1'b0;
    wait_done_a(bd);
    tick(3);
    check_msg_a("t4", bb, 64'h3F_3A_31_32_2E_3F_0D_0A);

    // Test 5: reset after the third tx_start, then restart from msg[0]
    set_digits(4'd5, 4'd4, 4'd3, 4'd2);
    bs = start_cnt_a; bd = done_cnt_a;
    send_a = 1'b1;
    tick(1);
    send_a = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if (start_cnt_a - bs == 3) break;
      tick(1);
    end
    check("t5_third_start", start_cnt_a - bs, 3);
    reset = 1'b1;
    send_a = 1'b1;
    tick(1);
    check("t5_rst_tx_start", tx_start_a, 0);
    check("t5_rst_busy", busy_a, 0);
    check("t5_rst_done", done_tick_a, 0);
    check("t5_rst_data", tx_data_a, 8'h00);
    tick(1);
    check("t5_send_in_reset", busy_a, 0);
    send_a = 1'b0;
    reset = 1'b0;
    tick(2);
    check("t5_no_done", done_cnt_a - bd, 0);
    set_digits(4'd6, 4'd1, 4'd0, 4'd8);
    bb = bytes_a.size(); bd = done_cnt_a;
    send_a = 1'b1;
    tick(1);
    send_a = 1'b0;
    wait_done_a(bd);
    tick(3);
    check_msg_a("t5", bb, 64'h36_3A_31_30_2E_38_0D_0A);

    // Test 6: stray tx_done_tick in IDLE does nothing
    bs = start_cnt_a; bd = done_cnt_a;
    stray_a = 1'b1;
    tick(1);
    stray_a = 1'b0;
    tick(5);
    check("t6_stray_starts", start_cnt_a - bs, 0);
    check("t6_stray_dones", done_cnt_a - bd, 0);
    check("t6_stray_busy", busy_a, 0);
    check("t6_no_back_to_back", consec_err, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
